// File: rtl/bsg_arb_dff_ctrl.sv
// Round-robin arbiter that feeds a single shared output register (EMPTY/FULL).
// Define BSG_ARB_DFF_CTRL_PIPE_EN to allow a consumed word to be replaced in the same cycle.
module bsg_arb_dff_ctrl #(
  parameter int unsigned width_p   = 16,
  parameter int unsigned num_req_p = 4
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_n_i,
  input  logic [num_req_p-1:0]                                   v_i,
  input  logic [num_req_p*width_p-1:0]                           data_i,
  output logic [num_req_p-1:0]                                   yumi_o,
  output logic                                                   v_o,
  output logic [width_p-1:0]                                     data_o,
  output logic [((num_req_p > 1) ? $clog2(num_req_p) : 1)-1:0]   tag_o,
  input  logic                                                   yumi_i
);

  localparam int unsigned tag_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned cnt_w = tag_w + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic [tag_w-1:0]   ptr;
  logic               load_ok;
  logic               gnt_v;
  logic               found;
  logic [tag_w-1:0]   gnt;
  logic [tag_w-1:0]   idx;
  logic [cnt_w-1:0]   sum;
  logic [width_p-1:0] gnt_data;

  // Cyclic first-valid search starting at ptr; grant is gated by load_ok and reset.
  always_comb begin
    load_ok  = 1'b1;
    found    = 1'b0;
    gnt      = '0;
    idx      = '0;
    sum      = '0;
    gnt_data = '0;
    yumi_o   = '0;
    if (state == FULL) begin
`ifdef BSG_ARB_DFF_CTRL_PIPE_EN
      load_ok = yumi_i;
`else
      load_ok = 1'b0;
`endif
    end
    for (int unsigned i = 0; i < num_req_p; i++) begin
      sum = {1'b0, ptr} + cnt_w'(i);
      if (sum >= cnt_w'(num_req_p)) sum = sum - cnt_w'(num_req_p);
      idx = tag_w'(sum);
      if (!found && v_i[idx]) begin
        found    = 1'b1;
        gnt      = idx;
        gnt_data = data_i[idx*width_p +: width_p];
      end
    end
    gnt_v = found & load_ok & reset_n_i;
    if (gnt_v) yumi_o[gnt] = 1'b1;
  end

  // State, shared register and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= EMPTY;
      data_o <= '0;
      tag_o  <= '0;
      ptr    <= '0;
    end else if (gnt_v) begin
      state  <= FULL;
      data_o <= gnt_data;
      tag_o  <= gnt;
      ptr    <= (gnt == tag_w'(num_req_p - 1)) ? '0 : gnt + tag_w'(1);
    end else if ((state == FULL) && yumi_i) begin
      state <= EMPTY;
    end
  end

  assign v_o = (state == FULL);

`ifndef SYNTHESIS
  // Downstream must never consume while nothing is held.
  a_yumi_while_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && (state == EMPTY)));
`endif

endmodule

// File: tb/tb_bsg_arb_dff_ctrl.sv
// Randomised self-checking bench for bsg_arb_dff_ctrl (width 16, 4 requesters).
module tb_bsg_arb_dff_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    v_in;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    yumi_out;
  logic            v_out;
  logic [W-1:0]    data_out;
  logic [1:0]      tag_out;
  logic            yumi_in;

  int checks = 0;
  int errors = 0;

  // reference model: what the shared register should hold
  bit       m_full;
  int       m_data;
  int       m_tag;
  int       m_ptr;

`ifdef BSG_ARB_DFF_CTRL_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  bsg_arb_dff_ctrl #(.width_p(W), .num_req_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .data_i(data_in),
    .yumi_o(yumi_out), .v_o(v_out), .data_o(data_out), .tag_o(tag_out),
    .yumi_i(yumi_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  // Round-robin rule: first requester with valid, starting at the pointer.
  function automatic int model_grant(input logic [N-1:0] v, input bit y);
    if (m_full && !(PIPE && y)) return -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (m_ptr + k) % N;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check yumi_o, then check registered outputs after posedge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit y, output int g);
    logic [N-1:0] exp_yumi;
    @(negedge clk);
    v_in = v; data_in = d; yumi_in = y;
    #1;
    g = model_grant(v, y);
    exp_yumi = '0;
    if (g >= 0) exp_yumi[g] = 1'b1;
    checks++;
    if (yumi_out !== exp_yumi) begin
      errors++;
      $display("FAIL yumi_o: got %b expected %b", yumi_out, exp_yumi);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1'b1;
      m_data = int'((d >> (g * W)) & 64'hFFFF);
      m_tag  = g;
      m_ptr  = (g + 1) % N;
    end else if (m_full && y) begin
      m_full = 1'b0;
    end
    #1;
    checks++;
    if (v_out !== m_full || data_out !== W'(m_data) || tag_out !== 2'(m_tag)) begin
      errors++;
      $display("FAIL regs: got v=%b data=%h tag=%0d expected v=%b data=%h tag=%0d",
               v_out, data_out, tag_out, m_full, W'(m_data), m_tag);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (v_out !== 1'b0 || data_out !== '0 || tag_out !== '0 || yumi_out !== '0) begin
      errors++;
      $display("FAIL %s: got v=%b data=%h tag=%0d yumi=%b expected all zero",
               tag, v_out, data_out, tag_out, yumi_out);
    end
  endtask

  // Asynchronous reset pulse mid-cycle; released idle so the next edge is a quiet EMPTY cycle.
  task automatic do_reset();
    @(negedge clk);
    #2;
    v_in = 4'b1111; yumi_in = 1'b1; data_in = rand_data();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk);
    v_in = '0; yumi_in = 1'b0;
    reset_n = 1'b1;
    m_full = 1'b0; m_data = 0; m_tag = 0; m_ptr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v_in = 4'b1111; yumi_in = 1'b1; data_in = rand_data();
    #3;
    check_reset_outputs("reset_initial");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("reset_initial_edge");
    end
    @(negedge clk);
    v_in = '0; yumi_in = 1'b0; reset_n = 1'b1;
    m_full = 1'b0; m_data = 0; m_tag = 0; m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int g;
    int got[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1111, rand_data(), m_full, g);
      if (g >= 0) got.push_back(g);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got.size() <= i || got[i] != exp_seq[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i,
                 (got.size() > i) ? got[i] : -1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_pointer_skip();
    int g;
    logic [N*W-1:0] d;
    do_reset();
    cycle(4'b0010, rand_data(), 1'b0, g);
    cycle(4'b0000, rand_data(), 1'b1, g);
    d = rand_data();
    cycle(4'b0001, d, 1'b0, g);
    checks++;
    if (g != 0 || tag_out !== 2'd0 || data_out !== d[15:0]) begin
      errors++;
      $display("FAIL ptr_skip: got tag=%0d data=%h expected tag=0 data=%h", tag_out, data_out, d[15:0]);
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [N*W-1:0] d;
    do_reset();
    d = rand_data();
    d[15:0] = 16'hA5A5;
    cycle(4'b0001, d, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, rand_data(), 1'b0, g);
      checks++;
      if (yumi_out !== '0 || data_out !== 16'hA5A5 || v_out !== 1'b1) begin
        errors++;
        $display("FAIL backpressure: got yumi=%b data=%h v=%b expected yumi=0000 data=a5a5 v=1",
                 yumi_out, data_out, v_out);
      end
    end
    cycle(4'b0000, rand_data(), 1'b1, g);
  endtask

  task automatic test_throughput();
    int g;
    int words = 0;
    int exp_words;
    exp_words = PIPE ? 10 : 5;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, rand_data(), m_full, g);
      if (g >= 0) words++;
    end
    checks++;
    if (words != exp_words) begin
      errors++;
      $display("FAIL throughput: got %0d words expected %0d", words, exp_words);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    cycle(4'b0100, rand_data(), 1'b0, g);
    checks++;
    if (tag_out !== 2'd2 || v_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got tag=%0d v=%b expected tag=2 v=1", tag_out, v_out);
    end
    do_reset();
    cycle(4'b1010, rand_data(), 1'b0, g);
    checks++;
    if (g != 1 || tag_out !== 2'd1) begin
      errors++;
      $display("FAIL mid_first_grant: got tag=%0d expected 1", tag_out);
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom()), rand_data(), m_full && ($urandom_range(0, 2) != 0), g);
    end
  endtask

  initial begin
    v_in = '0; data_in = '0; yumi_in = 1'b0; reset_n = 1'b0;
    m_full = 1'b0; m_data = 0; m_tag = 0; m_ptr = 0;
    test_reset();
    test_round_robin();
    test_pointer_skip();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
